// File: rtl/tpu_pkg.sv
// Shared types and constants for the 2x2 matmul host-side driver.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package tpu_pkg;

    localparam int NUM_OPERAND_BYTES = 8;
    localparam int NUM_RESULTS       = 4;

    typedef logic [7:0] fp8_t;

    typedef enum logic [2:0] {
        ST_LOAD      = 3'd0,
        ST_WAIT_DONE = 3'd1,
        ST_DRAIN     = 3'd2,
        ST_READ      = 3'd3,
        ST_SEND      = 3'd4
    } drv_state_e;

    // True when the byte counter points at the final operand byte (B3).
    function automatic logic is_last_operand(input logic [2:0] k);
        return k == 3'(NUM_OPERAND_BYTES - 1);
    endfunction

endpackage

// File: rtl/matmul_host_driver.sv
// Host-side initiator: streams 8 fp8 operands into the matmul controller, waits for done, reads and returns 4 results.
// Latency: 8th operand accept to first m_valid = 1 + D(done delay) + DRAIN_CYCLES + 4 + 1 cycles.
// Backpressure: s_ready only in LOAD; m_ready=0 stalls SEND with m_data/m_last held; done timeout aborts the job.
module matmul_host_driver
    import tpu_pkg::*;
#(
    parameter int DONE_TIMEOUT = 16,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    output logic       m_valid,
    output logic [7:0] m_data,
    output logic       m_last,
    input  logic       m_ready,
    output logic       load_en,
    output logic       load_sel_ab,
    output logic [1:0] load_index,
    output logic [7:0] in_data,
    output logic       output_en,
    output logic [1:0] output_sel,
    input  logic [7:0] out_data,
    input  logic       done,
    output logic       busy,
    output logic       error
);

    localparam int TMO_W = $clog2(DONE_TIMEOUT + 1);
    localparam int DRN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DONE_TIMEOUT - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    localparam logic [1:0]       RES_LAST = 2'(NUM_RESULTS - 1);

    drv_state_e       state_q, state_d;
    logic [2:0]       k_q, k_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [DRN_W-1:0] drn_q, drn_d;
    logic [1:0]       rd_q, rd_d;
    logic [1:0]       j_q, j_d;
    logic             rdy_q, rdy_d;
    logic             err_q, err_d;
    logic             ld_en_q, ld_en_d;
    logic             ld_ab_q, ld_ab_d;
    logic [1:0]       ld_idx_q, ld_idx_d;
    fp8_t             ld_dat_q, ld_dat_d;
    fp8_t             res_buf_q [NUM_RESULTS];
    logic             buf_we;
    logic             s_hs;

    // rdy_q is only ever high in LOAD, so it doubles as the state qualifier here.
    assign s_hs = s_valid && rdy_q;

    // Next-state, counter and registered-load-port decode.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        tmo_d    = tmo_q;
        drn_d    = drn_q;
        rd_d     = rd_q;
        j_d      = j_q;
        err_d    = 1'b0;
        ld_en_d  = 1'b0;
        ld_ab_d  = 1'b0;
        ld_idx_d = 2'd0;
        ld_dat_d = '0;
        buf_we   = 1'b0;
        unique case (state_q)
            ST_LOAD: begin
                if (s_hs) begin
                    ld_en_d  = 1'b1;
                    ld_dat_d = s_data;
                    ld_ab_d  = k_q[2];
                    ld_idx_d = k_q[1:0];
                    k_d      = k_q + 3'd1;
                    if (is_last_operand(k_q)) begin
                        state_d = ST_WAIT_DONE;
                        tmo_d   = '0;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (done) begin
                    tmo_d = '0;
                    drn_d = '0;
                    if (DRAIN_CYCLES == 0) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // Controller never answered: drop the job and go back to accepting operands.
                    err_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = ST_LOAD;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_DRAIN: begin
                if (drn_q == DRN_LAST) begin
                    drn_d   = '0;
                    state_d = ST_READ;
                end else begin
                    drn_d = drn_q + DRN_W'(1);
                end
            end
            ST_READ: begin
                buf_we = 1'b1;
                rd_d   = rd_q + 2'd1;
                if (rd_q == RES_LAST) begin
                    j_d     = 2'd0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (m_ready) begin
                    j_d = j_q + 2'd1;
                    if (j_q == RES_LAST) begin
                        state_d = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
        rdy_d = (state_d == ST_LOAD);
    end

    // State, counters and registered controller load port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_LOAD;
            k_q      <= '0;
            tmo_q    <= '0;
            drn_q    <= '0;
            rd_q     <= '0;
            j_q      <= '0;
            rdy_q    <= 1'b0;
            err_q    <= 1'b0;
            ld_en_q  <= 1'b0;
            ld_ab_q  <= 1'b0;
            ld_idx_q <= '0;
            ld_dat_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            tmo_q    <= tmo_d;
            drn_q    <= drn_d;
            rd_q     <= rd_d;
            j_q      <= j_d;
            rdy_q    <= rdy_d;
            err_q    <= err_d;
            ld_en_q  <= ld_en_d;
            ld_ab_q  <= ld_ab_d;
            ld_idx_q <= ld_idx_d;
            ld_dat_q <= ld_dat_d;
        end
    end

    // Result buffer: out_data is combinational on output_sel, captured at the end of each READ cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RESULTS; i++) begin
                res_buf_q[i] <= '0;
            end
        end else if (buf_we) begin
            res_buf_q[rd_q] <= out_data;
        end
    end

    assign s_ready     = rdy_q;
    assign load_en     = ld_en_q;
    assign load_sel_ab = ld_ab_q;
    assign load_index  = ld_idx_q;
    assign in_data     = ld_dat_q;
    assign output_en   = (state_q == ST_READ);
    assign output_sel  = output_en ? rd_q : 2'd0;
    assign m_valid     = (state_q == ST_SEND);
    assign m_data      = m_valid ? res_buf_q[j_q] : '0;
    assign m_last      = m_valid && (j_q == RES_LAST);
    assign busy        = (state_q != ST_LOAD);
    assign error       = err_q;

endmodule
